// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage core pipeline sequencing logic.
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR  = 2'd2
   } pipe_state_e;

   localparam int unsigned INSTR_W   = 32;
   localparam int unsigned REG_W     = 5;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [REG_W-1:0]   REG_ZERO  = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, taken-branch flush and
// data-memory wait handshake with timeout, plus stall counter and error flag.
module pipe_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rrwrite,
   input  logic             ex_branch_taken,
   input  logic             mem_memread,
   input  logic             mem_memwrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_bubble,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err
);

   localparam int unsigned WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

   pipe_state_e      state_q, state_d;
   logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic             err_q;

   logic mem_acc, stall_mem, load_use, timeout_hit;
   logic pc_en_c, ifid_en_c, ifid_flush_c, idex_en_c, idex_flush_c;
   logic exmem_en_c, memwb_bubble_c, dmem_req_c;

   // Hazard detection terms
   always_comb begin
      mem_acc     = mem_memread | mem_memwrite;
      stall_mem   = (state_q != ST_ERR) & mem_acc & ~dmem_ready;
      load_use    = ex_memread & (ex_rrwrite != REG_ZERO) &
                    ((ex_rrwrite == id_rs) | (id_uses_rt & (ex_rrwrite == id_rt)));
      timeout_hit = stall_mem & (wait_cnt_q == WC_LAST);
   end

   // State register and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (!pc_en_c && (state_q != ST_ERR) && (stall_cnt_q != '1))
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (state_d == ST_ERR)
            err_q <= 1'b1;
      end
   end

   // Next state and prioritised pipeline controls
   always_comb begin
      state_d        = state_q;
      wait_cnt_d     = stall_mem ? (wait_cnt_q + WC_W'(1)) : '0;
      pc_en_c        = 1'b1;
      ifid_en_c      = 1'b1;
      ifid_flush_c   = 1'b0;
      idex_en_c      = 1'b1;
      idex_flush_c   = 1'b0;
      exmem_en_c     = 1'b1;
      memwb_bubble_c = 1'b0;
      dmem_req_c     = mem_acc;

      case (state_q)
         ST_RUN: begin
            if (timeout_hit)    state_d = ST_ERR;
            else if (stall_mem) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (timeout_hit)     state_d = ST_ERR;
            else if (!stall_mem) state_d = ST_RUN;
         end
         default: state_d = ST_ERR;
      endcase

      if (state_q == ST_ERR) begin
         pc_en_c        = 1'b0;
         ifid_en_c      = 1'b0;
         idex_en_c      = 1'b0;
         exmem_en_c     = 1'b0;
         memwb_bubble_c = 1'b1;
         dmem_req_c     = 1'b0;
      end else if (stall_mem) begin
         pc_en_c        = 1'b0;
         ifid_en_c      = 1'b0;
         idex_en_c      = 1'b0;
         exmem_en_c     = 1'b0;
         memwb_bubble_c = 1'b1;
      end else if (ex_branch_taken) begin
         // Flushing the dependent instruction makes any load-use moot
         ifid_flush_c = 1'b1;
         idex_flush_c = 1'b1;
      end else if (load_use) begin
         pc_en_c      = 1'b0;
         ifid_en_c    = 1'b0;
         idex_flush_c = 1'b1;
      end
   end

   // Reset forces the pipeline quiet without waiting for a clock edge
   always_comb begin
      pc_en        = rst_n & pc_en_c;
      ifid_en      = rst_n & ifid_en_c;
      ifid_flush   = rst_n & ifid_flush_c;
      idex_en      = rst_n & idex_en_c;
      idex_flush   = rst_n & idex_flush_c;
      exmem_en     = rst_n & exmem_en_c;
      memwb_bubble = rst_n & memwb_bubble_c;
      dmem_req     = rst_n & dmem_req_c;
      stall_cnt    = stall_cnt_q;
      err          = err_q;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_rrwrite;
   logic        id_uses_rt, ex_memread, ex_branch_taken;
   logic        mem_memread, mem_memwrite, dmem_ready;
   logic        dmem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic        exmem_en, memwb_bubble, err;
   logic [15:0] stall_cnt;

   int errors = 0;
   int checks = 0;

   pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .ex_memread      (ex_memread),
      .ex_rrwrite      (ex_rrwrite),
      .ex_branch_taken (ex_branch_taken),
      .mem_memread     (mem_memread),
      .mem_memwrite    (mem_memwrite),
      .dmem_ready      (dmem_ready),
      .dmem_req        (dmem_req),
      .pc_en           (pc_en),
      .ifid_en         (ifid_en),
      .ifid_flush      (ifid_flush),
      .idex_en         (idex_en),
      .idex_flush      (idex_flush),
      .exmem_en        (exmem_en),
      .memwb_bubble    (memwb_bubble),
      .stall_cnt       (stall_cnt),
      .err             (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
      ex_memread = 1'b0; ex_rrwrite = 5'd0; ex_branch_taken = 1'b0;
      mem_memread = 1'b0; mem_memwrite = 1'b0; dmem_ready = 1'b0;
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();
      mem_memread = 1'b1;
      #3;
      chk("rst_pc_en", 32'(pc_en), 32'd0);
      chk("rst_ifid_en", 32'(ifid_en), 32'd0);
      chk("rst_idex_en", 32'(idex_en), 32'd0);
      chk("rst_exmem_en", 32'(exmem_en), 32'd0);
      chk("rst_dmem_req", 32'(dmem_req), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      idle();
      #3;
      chk("idle_pc_en", 32'(pc_en), 32'd1);
      chk("idle_exmem_en", 32'(exmem_en), 32'd1);

      // Load-use on rs
      tick();
      ex_memread = 1'b1; ex_rrwrite = 5'd5; id_rs = 5'd5;
      #3;
      chk("lu_pc_en", 32'(pc_en), 32'd0);
      chk("lu_ifid_en", 32'(ifid_en), 32'd0);
      chk("lu_idex_flush", 32'(idex_flush), 32'd1);
      chk("lu_idex_en", 32'(idex_en), 32'd1);
      chk("lu_exmem_en", 32'(exmem_en), 32'd1);
      tick();
      idle();
      #3;
      chk("lu_rel_pc_en", 32'(pc_en), 32'd1);
      chk("lu_rel_ifid_en", 32'(ifid_en), 32'd1);
      chk("lu_rel_idex_flush", 32'(idex_flush), 32'd0);
      chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);

      // Load-use on rt, only when rt is used
      tick();
      ex_memread = 1'b1; ex_rrwrite = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
      #3;
      chk("lurt_pc_en", 32'(pc_en), 32'd0);
      tick();
      id_uses_rt = 1'b0;
      #3;
      chk("lurt_unused_pc_en", 32'(pc_en), 32'd1);
      chk("lurt_stall_cnt", 32'(stall_cnt), 32'd2);

      // Destination r0 never stalls
      tick();
      idle();
      ex_memread = 1'b1; ex_rrwrite = 5'd0; id_rs = 5'd0;
      #3;
      chk("r0_pc_en", 32'(pc_en), 32'd1);
      chk("r0_idex_flush", 32'(idex_flush), 32'd0);

      // Branch wins over load-use
      tick();
      ex_memread = 1'b1; ex_rrwrite = 5'd5; id_rs = 5'd5; ex_branch_taken = 1'b1;
      #3;
      chk("br_ifid_flush", 32'(ifid_flush), 32'd1);
      chk("br_idex_flush", 32'(idex_flush), 32'd1);
      chk("br_pc_en", 32'(pc_en), 32'd1);
      chk("br_ifid_en", 32'(ifid_en), 32'd1);

      // Memory wait of 3 cycles
      tick();
      idle();
      mem_memread = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #3;
         chk("mw_exmem_en", 32'(exmem_en), 32'd0);
         chk("mw_bubble", 32'(memwb_bubble), 32'd1);
         chk("mw_dmem_req", 32'(dmem_req), 32'd1);
         chk("mw_pc_en", 32'(pc_en), 32'd0);
         tick();
      end
      dmem_ready = 1'b1;
      #3;
      chk("mw_rdy_dmem_req", 32'(dmem_req), 32'd1);
      chk("mw_rdy_exmem_en", 32'(exmem_en), 32'd1);
      chk("mw_rdy_bubble", 32'(memwb_bubble), 32'd0);
      tick();
      idle();
      #3;
      chk("mw_stall_cnt", 32'(stall_cnt), 32'd5);
      chk("mw_after_dmem_req", 32'(dmem_req), 32'd0);
      chk("mw_after_pc_en", 32'(pc_en), 32'd1);

      // Store completing in the request cycle costs nothing
      tick();
      mem_memwrite = 1'b1; dmem_ready = 1'b1;
      #3;
      chk("st0_dmem_req", 32'(dmem_req), 32'd1);
      chk("st0_pc_en", 32'(pc_en), 32'd1);
      tick();
      idle();
      #3;
      chk("st0_stall_cnt", 32'(stall_cnt), 32'd5);

      // Branch held during a 2-cycle memory wait
      tick();
      mem_memread = 1'b1; ex_branch_taken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #3;
         chk("bw_ifid_flush", 32'(ifid_flush), 32'd0);
         chk("bw_idex_flush", 32'(idex_flush), 32'd0);
         chk("bw_pc_en", 32'(pc_en), 32'd0);
         tick();
      end
      dmem_ready = 1'b1;
      #3;
      chk("bw_rdy_ifid_flush", 32'(ifid_flush), 32'd1);
      chk("bw_rdy_idex_flush", 32'(idex_flush), 32'd1);
      chk("bw_rdy_pc_en", 32'(pc_en), 32'd1);
      tick();
      idle();
      #3;
      chk("bw_stall_cnt", 32'(stall_cnt), 32'd7);

      // Reset mid-wait drops the request without a clock edge
      tick();
      mem_memread = 1'b1;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("rstw_dmem_req", 32'(dmem_req), 32'd0);
      chk("rstw_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      idle();

      // Timeout after 4 not-ready cycles
      tick();
      mem_memread = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #3;
         chk("to_err_pre", 32'(err), 32'd0);
         chk("to_dmem_req_pre", 32'(dmem_req), 32'd1);
         tick();
      end
      #3;
      chk("to_err", 32'(err), 32'd1);
      chk("to_pc_en", 32'(pc_en), 32'd0);
      chk("to_exmem_en", 32'(exmem_en), 32'd0);
      chk("to_dmem_req", 32'(dmem_req), 32'd0);
      chk("to_bubble", 32'(memwb_bubble), 32'd1);
      chk("to_stall_cnt", 32'(stall_cnt), 32'd4);
      dmem_ready = 1'b1;
      tick();
      #3;
      chk("err_sticky", 32'(err), 32'd1);
      chk("err_frozen_pc_en", 32'(pc_en), 32'd0);
      chk("err_stall_cnt", 32'(stall_cnt), 32'd4);

      // Reset out of ERR
      rst_n = 1'b0;
      #1;
      chk("rste_err", 32'(err), 32'd0);
      chk("rste_pc_en", 32'(pc_en), 32'd0);
      chk("rste_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();
      rst_n = 1'b1;
      idle();
      #3;
      chk("post_err", 32'(err), 32'd0);
      chk("post_pc_en", 32'(pc_en), 32'd1);
      chk("post_dmem_req", 32'(dmem_req), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It drives the enable, flush and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard types:
- load-use data hazards, with a one-bubble stall
- taken branches, with a two-stage flush
- variable-latency data-memory accesses, through a req/ready handshake with a wait timeout.

It also keeps a saturating stall-cycle counter and a sticky error flag.

## Interface
Parameters:
- TIMEOUT, 16: maximum consecutive not-ready memory cycles before the error state.
- CNT_W, 16: width of the stall counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- id_rs  in  5  ID-stage source register 1
- id_rt  in  5  ID-stage source register 2
- id_uses_rt  in  1  ID instruction reads rt
- ex_memread  in  1  EX instruction is a load
- ex_rrwrite  in  5  EX destination register
- ex_branch_taken  in  1  EX resolved a taken branch
- mem_memread  in  1  MEM instruction is a load
- mem_memwrite  in  1  MEM instruction is a store
- dmem_ready  in  1  data memory completes the access this cycle
- dmem_req  out  1  data memory access request
- pc_en  out  1  PC update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID clear to NOP
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX clear to bubble (control bits zeroed)
- exmem_en  out  1  EX/MEM load enable
- memwb_bubble  out  1  MEM/WB loads regwrite=0, memtoreg=0
- stall_cnt  out  CNT_W  saturating count of stalled cycles
- err  out  1  sticky memory-timeout error

## Operation
State machine, registered state:
- RUN: normal operation.
- WAIT: a memory access is outstanding.
- ERR: memory timeout; pipeline frozen until reset.

Combinational terms:
- mem_acc = mem_memread | mem_memwrite
- stall_mem = (state != ERR) & mem_acc & !dmem_ready
- load_use = ex_memread & (ex_rrwrite != 0) & ((ex_rrwrite == id_rs) | (id_uses_rt & ex_rrwrite == id_rt))

Control priority, highest first:
1. ERR
   - All enables are 0; flushes are 0; memwb_bubble = 1; dmem_req = 0.
2. stall_mem
   - pc_en, ifid_en, idex_en and exmem_en are 0; memwb_bubble = 1; dmem_req = 1.
   - ex_branch_taken and load_use are ignored. The same EX instruction re-presents them after release.
3. ex_branch_taken
   - ifid_flush = 1 and idex_flush = 1; all enables are 1.
   - A coincident load_use is ignored, because the dependent instruction is flushed.
4. load_use
   - pc_en = 0, ifid_en = 0, idex_flush = 1; idex_en and exmem_en are 1.
5. Otherwise
   - All enables are 1; flushes and bubble are 0.

In every state except ERR, dmem_req = mem_acc.

Transitions:
- RUN -> WAIT when stall_mem.
- WAIT -> RUN when dmem_ready.
- WAIT -> ERR when stall_mem and wait_cnt == TIMEOUT-1.
- ERR is left only by reset.

wait_cnt (width clog2(TIMEOUT)):
- Increments on each stall_mem cycle.
- Clears on any non-stall cycle.

stall_cnt:
- Increments, saturating at all-ones, on any cycle where pc_en = 0 and state != ERR.

err:
- Set on entry to ERR and stays set.

## Timing
- Reset:
  - state = RUN, wait_cnt = 0, stall_cnt = 0, err = 0.
  - While rst_n is low, all enables are 0 and dmem_req = 0.
  - Reset asserted mid-WAIT drops dmem_req immediately (asynchronous).
- Stall and flush controls are combinational from the current-cycle inputs and state, with zero latency.
- Memory handshake:
  - dmem_ready sampled with dmem_req in the same cycle completes the access with no stall.
  - dmem_req stays high, and the MEM-stage inputs are held stable, until ready.
- Memory latency N ≥ 1 not-ready cycles gives exactly N stalled cycles, N bubbles into MEM/WB, and stall_cnt += N.
- Timeout: TIMEOUT consecutive not-ready cycles moves the FSM to ERR on the next edge; err rises in that same cycle.
- Load-use costs exactly one bubble. The cycle after, ex_memread belongs to the bubble, so the stall releases.
- A branch costs exactly two flushed slots.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum (RUN/WAIT/ERR)
  - the NOP encoding
  - REG_ZERO = 5'd0
- No sub-module. The FSM, the hazard compare logic and the counters live in one file.

## Test plan
- Load-use: ex_memread=1, ex_rrwrite=5, id_rs=5 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables are 1; stall_cnt=1.
- Load-use with rd=0: ex_rrwrite=0, id_rs=0 -> no stall.
- Branch while load_use is also true: ex_branch_taken=1 -> ifid_flush=idex_flush=1 and pc_en=1.
- Memory wait: mem_memread=1, dmem_ready low for 3 cycles then high -> 3 cycles with exmem_en=0 and memwb_bubble=1; dmem_req is high for all 4 cycles; state returns to RUN; stall_cnt=3.
- Branch during memory wait: ex_branch_taken held during a 2-cycle wait -> no flush while waiting; flushes fire in the ready cycle.
- Timeout with TIMEOUT=4: dmem_ready held low -> ERR after the 4th cycle and err=1. Then rst_n low mid-ERR -> all outputs return to reset values, and err=0 after release.
